// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register: forwarding select
// encodings, the zero-register specifier and the bundled EX-stage control word.
package mips_pipe_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  localparam int REG_ZERO     = 0;
  localparam int CTRL_ALUOP_W = 4;

  typedef struct packed {
    logic                    RegWrite;
    logic                    MemRead;
    logic                    MemWrite;
    logic                    MemToReg;
    logic                    ALUSrc;
    logic [CTRL_ALUOP_W-1:0] ALUOp;
  } ex_ctrl_t;

endpackage

// File: rtl/fwd_sel_calc.sv
// Forwarding select for one EX operand, resolved a cycle early from the
// instruction about to enter EX/MEM and the one about to enter MEM/WB.
module fwd_sel_calc
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  output logic [1:0]            sel
);

  logic ex_hit;
  logic mem_hit;

  // Register 0 is hardwired, so a write to it must never be forwarded.
  assign ex_hit  = ex_reg_write  && (ex_dest  != REG_ADDR_W'(REG_ZERO)) && (ex_dest  == src);
  assign mem_hit = mem_reg_write && (mem_dest != REG_ADDR_W'(REG_ZERO)) && (mem_dest == src);

  always_comb begin
    sel = FWD_REGFILE;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with bubble insertion, global hold, load-use detect
// and registered forwarding selects. Optional counters under HAZARD_PERF_EN.
module id_ex_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Hold,
  input  logic                  Flush,
  input  logic [DATA_W-1:0]     ID_ReadData1,
  input  logic [DATA_W-1:0]     ID_ReadData2,
  input  logic [DATA_W-1:0]     ID_SignExtImm,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic [REG_ADDR_W-1:0] ID_Rd,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_MemWrite,
  input  logic                  ID_MemToReg,
  input  logic                  ID_ALUSrc,
  input  logic                  ID_RegDst,
  input  logic [ALUOP_W-1:0]    ID_ALUOp,
  input  logic                  EXMEM_RegWrite,
  input  logic [REG_ADDR_W-1:0] EXMEM_WriteReg,
  output logic [DATA_W-1:0]     EX_ReadData1,
  output logic [DATA_W-1:0]     EX_ReadData2,
  output logic [DATA_W-1:0]     EX_SignExtImm,
  output logic [REG_ADDR_W-1:0] EX_Rs,
  output logic [REG_ADDR_W-1:0] EX_Rt,
  output logic [REG_ADDR_W-1:0] EX_WriteReg,
  output logic                  EX_RegWrite,
  output logic                  EX_MemRead,
  output logic                  EX_MemWrite,
  output logic                  EX_MemToReg,
  output logic                  EX_ALUSrc,
  output logic [ALUOP_W-1:0]    EX_ALUOp,
  output logic [1:0]            EX_ForwardA,
  output logic [1:0]            EX_ForwardB,
`ifdef HAZARD_PERF_EN
  output logic [31:0]           BubbleCount,
  output logic [31:0]           ForwardExMemCount,
  output logic [31:0]           ForwardMemWbCount,
`endif
  output logic                  LoadUseHazard
);

  logic [DATA_W-1:0]     rd1_reg, rd1_next;
  logic [DATA_W-1:0]     rd2_reg, rd2_next;
  logic [DATA_W-1:0]     imm_reg, imm_next;
  logic [REG_ADDR_W-1:0] rs_reg, rs_next;
  logic [REG_ADDR_W-1:0] rt_reg, rt_next;
  logic [REG_ADDR_W-1:0] wr_reg, wr_next;
  ex_ctrl_t              ctrl_reg, ctrl_next;
  logic [1:0]            fwd_a_reg, fwd_a_next;
  logic [1:0]            fwd_b_reg, fwd_b_next;
  logic                  bubble;

  logic [REG_ADDR_W-1:0] fwd_src [2];
  logic [1:0]            fwd_sel [2];

  assign fwd_src[0] = ID_Rs;
  assign fwd_src[1] = ID_Rt;

  // The producer now in EX moves to EX/MEM on this edge; EX/MEM moves to MEM/WB.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_sel_calc #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_sel_calc (
        .src          (fwd_src[gi]),
        .ex_reg_write (ctrl_reg.RegWrite),
        .ex_dest      (wr_reg),
        .mem_reg_write(EXMEM_RegWrite),
        .mem_dest     (EXMEM_WriteReg),
        .sel          (fwd_sel[gi])
      );
    end
  endgenerate

  assign LoadUseHazard = ctrl_reg.MemRead && (wr_reg != REG_ADDR_W'(REG_ZERO)) &&
                         ((wr_reg == ID_Rs) || (wr_reg == ID_Rt));
  assign bubble = Flush || LoadUseHazard;

  always_comb begin
    rd1_next           = ID_ReadData1;
    rd2_next           = ID_ReadData2;
    imm_next           = ID_SignExtImm;
    rs_next            = ID_Rs;
    rt_next            = ID_Rt;
    wr_next            = ID_RegDst ? ID_Rd : ID_Rt;
    ctrl_next.RegWrite = ID_RegWrite;
    ctrl_next.MemRead  = ID_MemRead;
    ctrl_next.MemWrite = ID_MemWrite;
    ctrl_next.MemToReg = ID_MemToReg;
    ctrl_next.ALUSrc   = ID_ALUSrc;
    ctrl_next.ALUOp    = ID_ALUOp;
    fwd_a_next         = fwd_sel[0];
    fwd_b_next         = fwd_sel[1];
    if (bubble) begin
      rd1_next   = '0;
      rd2_next   = '0;
      imm_next   = '0;
      rs_next    = '0;
      rt_next    = '0;
      wr_next    = '0;
      ctrl_next  = '0;
      fwd_a_next = FWD_REGFILE;
      fwd_b_next = FWD_REGFILE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd1_reg   <= '0;
      rd2_reg   <= '0;
      imm_reg   <= '0;
      rs_reg    <= '0;
      rt_reg    <= '0;
      wr_reg    <= '0;
      ctrl_reg  <= '0;
      fwd_a_reg <= FWD_REGFILE;
      fwd_b_reg <= FWD_REGFILE;
    end else if (!Hold) begin
      rd1_reg   <= rd1_next;
      rd2_reg   <= rd2_next;
      imm_reg   <= imm_next;
      rs_reg    <= rs_next;
      rt_reg    <= rt_next;
      wr_reg    <= wr_next;
      ctrl_reg  <= ctrl_next;
      fwd_a_reg <= fwd_a_next;
      fwd_b_reg <= fwd_b_next;
    end
  end

  assign EX_ReadData1  = rd1_reg;
  assign EX_ReadData2  = rd2_reg;
  assign EX_SignExtImm = imm_reg;
  assign EX_Rs         = rs_reg;
  assign EX_Rt         = rt_reg;
  assign EX_WriteReg   = wr_reg;
  assign EX_RegWrite   = ctrl_reg.RegWrite;
  assign EX_MemRead    = ctrl_reg.MemRead;
  assign EX_MemWrite   = ctrl_reg.MemWrite;
  assign EX_MemToReg   = ctrl_reg.MemToReg;
  assign EX_ALUSrc     = ctrl_reg.ALUSrc;
  assign EX_ALUOp      = ctrl_reg.ALUOp;
  assign EX_ForwardA   = fwd_a_reg;
  assign EX_ForwardB   = fwd_b_reg;

`ifdef HAZARD_PERF_EN
  logic [31:0] bubble_cnt_reg;
  logic [31:0] exmem_cnt_reg;
  logic [31:0] memwb_cnt_reg;

  // Each counter advances at most once per edge even when both selects match.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bubble_cnt_reg <= '0;
      exmem_cnt_reg  <= '0;
      memwb_cnt_reg  <= '0;
    end else if (!Hold) begin
      if (bubble) bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
      if (fwd_a_next == FWD_EXMEM || fwd_b_next == FWD_EXMEM)
        exmem_cnt_reg <= exmem_cnt_reg + 32'd1;
      if (fwd_a_next == FWD_MEMWB || fwd_b_next == FWD_MEMWB)
        memwb_cnt_reg <= memwb_cnt_reg + 32'd1;
    end
  end

  assign BubbleCount       = bubble_cnt_reg;
  assign ForwardExMemCount = exmem_cnt_reg;
  assign ForwardMemWbCount = memwb_cnt_reg;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized plus directed bench for id_ex_stage_reg against a behavioural
// pipeline-register model; counters checked when HAZARD_PERF_EN is defined.
module tb_id_ex_stage_reg;

  logic        Clk = 1'b0;
  logic        Reset, Hold, Flush;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_SignExtImm;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst;
  logic [3:0]  ID_ALUOp;
  logic        EXMEM_RegWrite;
  logic [4:0]  EXMEM_WriteReg;
  logic [31:0] EX_ReadData1, EX_ReadData2, EX_SignExtImm;
  logic [4:0]  EX_Rs, EX_Rt, EX_WriteReg;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc;
  logic [3:0]  EX_ALUOp;
  logic [1:0]  EX_ForwardA, EX_ForwardB;
  logic        LoadUseHazard;
`ifdef HAZARD_PERF_EN
  logic [31:0] BubbleCount, ForwardExMemCount, ForwardMemWbCount;
`endif

  always #5 Clk = ~Clk;

  id_ex_stage_reg dut (
    .Clk(Clk), .Reset(Reset), .Hold(Hold), .Flush(Flush),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_SignExtImm(ID_SignExtImm),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
    .ID_ALUOp(ID_ALUOp), .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_WriteReg(EXMEM_WriteReg),
    .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_SignExtImm(EX_SignExtImm),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_WriteReg(EX_WriteReg),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemToReg(EX_MemToReg), .EX_ALUSrc(EX_ALUSrc), .EX_ALUOp(EX_ALUOp),
    .EX_ForwardA(EX_ForwardA), .EX_ForwardB(EX_ForwardB),
`ifdef HAZARD_PERF_EN
    .BubbleCount(BubbleCount), .ForwardExMemCount(ForwardExMemCount),
    .ForwardMemWbCount(ForwardMemWbCount),
`endif
    .LoadUseHazard(LoadUseHazard)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Model of what the EX stage should hold.
  logic [31:0] m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs, m_rt, m_wr;
  logic        m_rw, m_mr, m_mw, m_m2r, m_as;
  logic [3:0]  m_op;
  logic [1:0]  m_fa, m_fb;
  int unsigned m_bub, m_exm, m_mwb;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] x);
    // The EX instruction is the newer producer and wins over EX/MEM.
    if (m_rw && m_wr != 5'd0 && m_wr == x) return 2'b10;
    if (EXMEM_RegWrite && EXMEM_WriteReg != 5'd0 && EXMEM_WriteReg == x) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic lu_model();
    return m_mr && m_wr != 5'd0 && (m_wr == ID_Rs || m_wr == ID_Rt);
  endfunction

  task automatic model_clear();
    {m_rd1, m_rd2, m_imm, m_rs, m_rt, m_wr} = '0;
    {m_rw, m_mr, m_mw, m_m2r, m_as, m_op, m_fa, m_fb} = '0;
  endtask

  task automatic model_edge();
    logic [1:0] fa, fb;
    if (Reset) begin
      model_clear();
      m_bub = 0; m_exm = 0; m_mwb = 0;
    end else if (!Hold) begin
      if (Flush || lu_model()) begin
        model_clear();
        m_bub++;
      end else begin
        fa = fwd_model(ID_Rs);
        fb = fwd_model(ID_Rt);
        if (fa == 2'b10 || fb == 2'b10) m_exm++;
        if (fa == 2'b01 || fb == 2'b01) m_mwb++;
        m_rd1 = ID_ReadData1; m_rd2 = ID_ReadData2; m_imm = ID_SignExtImm;
        m_rs = ID_Rs; m_rt = ID_Rt; m_wr = ID_RegDst ? ID_Rd : ID_Rt;
        m_rw = ID_RegWrite; m_mr = ID_MemRead; m_mw = ID_MemWrite;
        m_m2r = ID_MemToReg; m_as = ID_ALUSrc; m_op = ID_ALUOp;
        m_fa = fa; m_fb = fb;
      end
    end
  endtask

  task automatic compare_all();
    check("data", {EX_ReadData1, EX_ReadData2, EX_SignExtImm}, {m_rd1, m_rd2, m_imm});
    check("spec", {EX_Rs, EX_Rt, EX_WriteReg}, {m_rs, m_rt, m_wr});
    check("ctrl", {EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_ALUOp},
                  {m_rw, m_mr, m_mw, m_m2r, m_as, m_op});
    check("fwdA", EX_ForwardA, m_fa);
    check("fwdB", EX_ForwardB, m_fb);
`ifdef HAZARD_PERF_EN
    check("cnt_bubble", BubbleCount, m_bub);
    check("cnt_exmem", ForwardExMemCount, m_exm);
    check("cnt_memwb", ForwardMemWbCount, m_mwb);
`endif
  endtask

  // Inputs are set at a negedge; this checks the hazard, takes one edge, compares.
  task automatic step();
    #1;
    check("load_use", LoadUseHazard, lu_model());
    model_edge();
    @(posedge Clk);
    #1;
    compare_all();
    @(negedge Clk);
  endtask

  task automatic rand_id();
    ID_ReadData1 = $urandom; ID_ReadData2 = $urandom; ID_SignExtImm = $urandom;
    ID_Rs = 5'($urandom_range(0, 7)); ID_Rt = 5'($urandom_range(0, 7));
    ID_Rd = 5'($urandom_range(0, 7));
    ID_RegWrite = 1'($urandom); ID_MemRead = ($urandom_range(0, 3) == 0);
    ID_MemWrite = 1'($urandom); ID_MemToReg = 1'($urandom);
    ID_ALUSrc = 1'($urandom); ID_RegDst = 1'($urandom); ID_ALUOp = 4'($urandom);
    EXMEM_RegWrite = 1'($urandom); EXMEM_WriteReg = 5'($urandom_range(0, 7));
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic rdst);
    rand_id();
    ID_Rs = rs; ID_Rt = rt; ID_Rd = rd;
    ID_RegWrite = rw; ID_MemRead = mr; ID_RegDst = rdst;
    EXMEM_RegWrite = 1'b0; EXMEM_WriteReg = 5'd0;
    Reset = 1'b0; Hold = 1'b0; Flush = 1'b0;
  endtask

  task automatic do_flush();
    rand_id(); Reset = 1'b0; Hold = 1'b0; Flush = 1'b1;
    step();
  endtask

  initial begin
    model_clear();
    m_bub = 0; m_exm = 0; m_mwb = 0;
    Reset = 1'b1; Hold = 1'b0; Flush = 1'b0;
    rand_id();
    @(negedge Clk);
    // Reset with random inputs, then release and capture.
    for (int i = 0; i < 2; i++) begin rand_id(); step(); end
    check("rst_all_zero", {EX_ReadData1, EX_WriteReg, EX_RegWrite, EX_ForwardA, EX_ForwardB}, '0);
    set_id(5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1);
    step();

    // EX holds add $3; Rs=3 forwards from EX/MEM.
    do_flush();
    set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1); step();
    set_id(5'd3, 5'd4, 5'd9, 1'b0, 1'b0, 1'b1); step();
    check("add3_fwdA", EX_ForwardA, 2'b10);
    check("add3_fwdB", EX_ForwardB, 2'b00);

    // EX/MEM priority over MEM/WB.
    do_flush();
    set_id(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1); step();
    set_id(5'd6, 5'd5, 5'd9, 1'b0, 1'b0, 1'b1);
    EXMEM_RegWrite = 1'b1; EXMEM_WriteReg = 5'd5; step();
    check("prio_fwdB", EX_ForwardB, 2'b10);
    do_flush();
    set_id(5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b1); step();
    set_id(5'd6, 5'd5, 5'd9, 1'b0, 1'b0, 1'b1);
    EXMEM_RegWrite = 1'b1; EXMEM_WriteReg = 5'd5; step();
    check("memwb_fwdB", EX_ForwardB, 2'b01);
    do_flush();
    set_id(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1); step();
    set_id(5'd6, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1);
    EXMEM_RegWrite = 1'b1; EXMEM_WriteReg = 5'd0; step();
    check("zero_fwdB", EX_ForwardB, 2'b00);

    // lw $8 then a consumer: bubble, then reload forwarding from EX/MEM input.
    do_flush();
    set_id(5'd1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0); step();
    set_id(5'd8, 5'd2, 5'd9, 1'b0, 1'b0, 1'b1);
    #1 check("lu_detect", LoadUseHazard, 1'b1);
    step();
    check("lu_bubble", {EX_RegWrite, EX_MemRead, EX_WriteReg, EX_ForwardA}, '0);
    EXMEM_RegWrite = 1'b1; EXMEM_WriteReg = 5'd8; step();
    check("lu_reload_fwdA", EX_ForwardA, 2'b01);
    check("lu_reload_rs", EX_Rs, 5'd8);

    // Hold freezes, Hold beats Flush, then Flush alone bubbles.
    set_id(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b1); step();
    for (int i = 0; i < 3; i++) begin rand_id(); Hold = 1'b1; step(); end
    rand_id(); Hold = 1'b1; Flush = 1'b1; step();
    check("hold_flush_rs", EX_Rs, 5'd3);
    rand_id(); Hold = 1'b0; Flush = 1'b1; step();
    check("flush_ctrl", {EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc,
                         EX_ForwardA, EX_ForwardB}, '0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_id();
      Reset = ($urandom_range(0, 49) == 0);
      Hold  = ($urandom_range(0, 5) == 0);
      Flush = ($urandom_range(0, 7) == 0);
      step();
    end

`ifdef HAZARD_PERF_EN
    rand_id(); Reset = 1'b1; Hold = 1'b0; Flush = 1'b0; step();
    check("cnt_reset", {BubbleCount, ForwardExMemCount, ForwardMemWbCount}, '0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
